line_mem_responder: RTL and testbench

- Main-memory responder on the refill side of the data cache in the MIPS pipeline.
- Accepts one line-sized read (refill) or write (write-back) request from the cache.
- Models a fixed access latency and transfers the line as a burst of 32-bit words.
- The cache holds stopCPU asserted for the whole transaction; this block only ever responds, never initiates.

---
 rtl/line_mem_if.sv | 34 +++
 rtl/line_mem_responder.sv | 144 ++++++++++++++
 tb/tb_line_mem_responder.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/line_mem_if.sv
// Cache-to-main-memory refill/write-back bus for line_mem_responder.
// memErr exists only when LINE_MEM_RESPONDER_ALIGN_CHECK_EN is defined.
interface line_mem_if;
  logic        memReq;
  logic        memWrite;
  logic [31:0] memAddr;
  logic [31:0] memWData;
  logic        memWValid;
  logic        memWReady;
  logic        memAck;
  logic [31:0] memRData;
  logic        memRValid;
  logic        memDone;
  logic        busy;
`ifdef LINE_MEM_RESPONDER_ALIGN_CHECK_EN
  logic        memErr;
`endif

  modport master (
`ifdef LINE_MEM_RESPONDER_ALIGN_CHECK_EN
    input  memErr,
`endif
    output memReq, memWrite, memAddr, memWData, memWValid,
    input  memWReady, memAck, memRData, memRValid, memDone, busy
  );

  modport slave (
`ifdef LINE_MEM_RESPONDER_ALIGN_CHECK_EN
    output memErr,
`endif
    input  memReq, memWrite, memAddr, memWData, memWValid,
    output memWReady, memAck, memRData, memRValid, memDone, busy
  );
endinterface

// File: rtl/line_mem_responder.sv
// Main-memory responder for data-cache line refills and write-backs.
// Optional LINE_MEM_RESPONDER_ALIGN_CHECK_EN adds memErr for misaligned requests.
module line_mem_responder #(
  parameter int unsigned LINE_WORDS  = 4,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 8
) (
  input logic         clk,
  input logic         rst,
  line_mem_if.slave   bus
);
  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned OFF_W = $clog2(LINE_WORDS);
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(LATENCY - 1);
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

  typedef enum logic [2:0] {IDLE, RWAIT, RBURST, WBURST, WWAIT} state_t;

  state_t                   state;
  logic [IDX_W-OFF_W-1:0]   line_q;
  logic [OFF_W-1:0]         idx;
  logic [OFF_W-1:0]         idx_nxt;
  logic [CNT_W-1:0]         cnt;
  logic                     err_q;
  logic                     misaligned;
  logic                     mem_we;
  logic                     unused_addr;
  logic [31:0]              mem [DEPTH_WORDS];

`ifdef LINE_MEM_RESPONDER_ALIGN_CHECK_EN
  assign misaligned  = |bus.memAddr[OFF_W+1:0];
  assign unused_addr = ^bus.memAddr[31:IDX_W+2];
`else
  assign misaligned  = 1'b0;
  assign unused_addr = ^{bus.memAddr[31:IDX_W+2], bus.memAddr[OFF_W+1:0]};
`endif

  always_comb begin
    idx_nxt = idx + 1'b1;
    mem_we  = (state == WBURST) && bus.memWValid && bus.memWReady && !err_q;
  end

  // Gated by rst so a beat presented on a reset edge is never committed.
  always_ff @(posedge clk) begin
    if (rst && mem_we)
      mem[{line_q, idx}] <= bus.memWData;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      line_q        <= '0;
      idx           <= '0;
      cnt           <= '0;
      err_q         <= 1'b0;
      bus.memAck    <= 1'b0;
      bus.memWReady <= 1'b0;
      bus.memRData  <= '0;
      bus.memRValid <= 1'b0;
      bus.memDone   <= 1'b0;
      bus.busy      <= 1'b0;
`ifdef LINE_MEM_RESPONDER_ALIGN_CHECK_EN
      bus.memErr    <= 1'b0;
`endif
    end else begin
      bus.memAck <= 1'b0;
      case (state)
        // Completion states hand over to IDLE with busy still set, so the
        // memDone cycle itself can never accept a new request.
        IDLE: begin
          bus.memRValid <= 1'b0;
          bus.memDone   <= 1'b0;
          bus.busy      <= 1'b0;
`ifdef LINE_MEM_RESPONDER_ALIGN_CHECK_EN
          bus.memErr    <= 1'b0;
`endif
          if (bus.memReq && !bus.busy) begin
            line_q     <= bus.memAddr[IDX_W+1:OFF_W+2];
            err_q      <= misaligned;
            idx        <= '0;
            cnt        <= '0;
            bus.memAck <= 1'b1;
            bus.busy   <= 1'b1;
            if (bus.memWrite) begin
              state         <= WBURST;
              bus.memWReady <= 1'b1;
            end else begin
              state <= RWAIT;
            end
          end
        end
        RWAIT: begin
          if (cnt == LAST_CNT) begin
            if (err_q) begin
              bus.memDone <= 1'b1;
`ifdef LINE_MEM_RESPONDER_ALIGN_CHECK_EN
              bus.memErr  <= 1'b1;
`endif
              state       <= IDLE;
            end else begin
              bus.memRValid <= 1'b1;
              bus.memRData  <= mem[{line_q, idx}];
              state         <= RBURST;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RBURST: begin
          idx          <= idx_nxt;
          bus.memRData <= mem[{line_q, idx_nxt}];
          if (idx_nxt == LAST_BEAT) begin
            bus.memDone <= 1'b1;
            state       <= IDLE;
          end
        end
        WBURST: begin
          if (bus.memWValid && bus.memWReady) begin
            if (idx == LAST_BEAT) begin
              bus.memWReady <= 1'b0;
              cnt           <= '0;
              state         <= WWAIT;
            end else begin
              idx <= idx_nxt;
            end
          end
        end
        WWAIT: begin
          if (cnt == LAST_CNT) begin
            bus.memDone <= 1'b1;
`ifdef LINE_MEM_RESPONDER_ALIGN_CHECK_EN
            bus.memErr  <= err_q;
`endif
            state       <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_line_mem_responder.sv
// Directed bench for line_mem_responder (LINE_WORDS=4, DEPTH_WORDS=1024, LATENCY=8).
module tb_line_mem_responder;
  typedef logic [3:0][31:0] line_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int unsigned vectors = 0;
  int unsigned fails   = 0;

  line_mem_if bus();

  line_mem_responder #(.LINE_WORDS(4), .DEPTH_WORDS(1024), .LATENCY(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic line_t mk(input logic [31:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"},   32'(bus.busy),      32'h0);
    chk({tag, "_ack"},    32'(bus.memAck),    32'h0);
    chk({tag, "_wready"}, 32'(bus.memWReady), 32'h0);
    chk({tag, "_rvalid"}, 32'(bus.memRValid), 32'h0);
    chk({tag, "_done"},   32'(bus.memDone),   32'h0);
  endtask

  // Called in the memAck cycle of a read; checks latency, beats and release.
  task automatic read_tail(input line_t d);
    chk("rd_rvalid_ack", 32'(bus.memRValid), 32'h0);
    for (int c = 2; c <= 8; c++) begin
      step();
      chk("rd_wait_rvalid", 32'(bus.memRValid), 32'h0);
      chk("rd_wait_ack",    32'(bus.memAck),    32'h0);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rd_rvalid", 32'(bus.memRValid), 32'h1);
      chk("rd_data",   bus.memRData,       d[i]);
      chk("rd_done",   32'(bus.memDone),   32'(i == 3));
      chk("rd_busy",   32'(bus.busy),      32'h1);
    end
    step();
    chk_idle_outputs("rd_end");
  endtask

  task automatic do_read(input logic [31:0] addr, input line_t d);
    bus.memReq   = 1'b1;
    bus.memWrite = 1'b0;
    bus.memAddr  = addr;
    step();
    chk("rd_ack",  32'(bus.memAck), 32'h1);
    chk("rd_busy", 32'(bus.busy),   32'h1);
    bus.memReq = 1'b0;
    read_tail(d);
  endtask

  // pat bit c = memWValid in the c-th cycle after memAck; junk beats are
  // driven during stalls and during the post-burst wait.
  task automatic do_write(input logic [31:0] addr, input line_t d, input logic [7:0] pat);
    int unsigned k;
    k = 0;
    bus.memReq   = 1'b1;
    bus.memWrite = 1'b1;
    bus.memAddr  = addr;
    step();
    chk("wr_ack",    32'(bus.memAck),    32'h1);
    chk("wr_wready", 32'(bus.memWReady), 32'h1);
    bus.memReq = 1'b0;
    for (int c = 0; c < 8 && k < 4; c++) begin
      bus.memWValid = pat[c];
      bus.memWData  = pat[c] ? d[k] : 32'hDEAD_BEEF;
      step();
      if (pat[c]) k++;
      chk("wr_wready_track", 32'(bus.memWReady), 32'(k < 4));
    end
    bus.memWValid = 1'b1;
    bus.memWData  = 32'hBAD0_BAD0;
    for (int c = 1; c <= 8; c++) begin
      step();
      chk("wr_done", 32'(bus.memDone), 32'(c == 8));
      chk("wr_busy", 32'(bus.busy),    32'h1);
    end
    bus.memWValid = 1'b0;
    step();
    chk_idle_outputs("wr_end");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.memReq    = 1'b1;
    bus.memWrite  = 1'b0;
    bus.memAddr   = 32'h100;
    bus.memWData  = '0;
    bus.memWValid = 1'b0;

    // Reset with a request pending: nothing may be accepted.
    step();
    step();
    chk_idle_outputs("reset");
    chk("reset_rdata", bus.memRData, 32'h0);
    rst        = 1'b1;
    bus.memReq = 1'b0;
    step();
    chk_idle_outputs("post_reset");

    // Preload words 0x40..0x43, then refill them.
    do_write(32'h100, mk(32'hA0, 32'hA1, 32'hA2, 32'hA3), 8'b0000_1111);
    do_read (32'h100, mk(32'hA0, 32'hA1, 32'hA2, 32'hA3));

    // Write-back with stalls 1,0,1,1,0,1 then read back.
    do_write(32'h200, mk(32'h11, 32'h22, 32'h33, 32'h44), 8'b0010_1101);
    do_read (32'h200, mk(32'h11, 32'h22, 32'h33, 32'h44));

    do_write(32'h0, mk(32'hB0, 32'hB1, 32'hB2, 32'hB3), 8'b0000_1111);
`ifdef LINE_MEM_RESPONDER_ALIGN_CHECK_EN
    bus.memReq   = 1'b1;
    bus.memWrite = 1'b0;
    bus.memAddr  = 32'h104;
    step();
    chk("err_ack", 32'(bus.memAck), 32'h1);
    bus.memReq = 1'b0;
    for (int c = 2; c <= 8; c++) begin
      step();
      chk("err_wait_done",   32'(bus.memDone),   32'h0);
      chk("err_wait_rvalid", 32'(bus.memRValid), 32'h0);
    end
    step();
    chk("err_done",   32'(bus.memDone),   32'h1);
    chk("err_flag",   32'(bus.memErr),    32'h1);
    chk("err_rvalid", 32'(bus.memRValid), 32'h0);
    step();
    chk_idle_outputs("err_end");
    chk("err_clear", 32'(bus.memErr), 32'h0);
`else
    // Unaligned, and above the storage size: both map to line base 0.
    do_read(32'h0000_100C,            mk(32'hB0, 32'hB1, 32'hB2, 32'hB3));
    do_read(32'h0000_100C + 4096 * 4, mk(32'hB0, 32'hB1, 32'hB2, 32'hB3));
`endif

    // Second request held during RWAIT is ignored until after memDone.
    bus.memReq   = 1'b1;
    bus.memWrite = 1'b0;
    bus.memAddr  = 32'h200;
    step();
    chk("busy_ack1", 32'(bus.memAck), 32'h1);
    bus.memAddr = 32'h100;
    for (int c = 2; c <= 12; c++) begin
      step();
      chk("busy_noack", 32'(bus.memAck), 32'h0);
      if (c == 10) chk("busy_beat1", bus.memRData, 32'h22);
    end
    chk("busy_done1", 32'(bus.memDone), 32'h1);
    step();
    chk("busy_gap_busy", 32'(bus.busy),   32'h0);
    chk("busy_gap_ack",  32'(bus.memAck), 32'h0);
    step();
    chk("busy_ack2", 32'(bus.memAck), 32'h1);
    bus.memReq = 1'b0;
    read_tail(mk(32'hA0, 32'hA1, 32'hA2, 32'hA3));

    // Reset on the second write beat: only beat 0 lands.
    do_write(32'h300, mk(32'hC0, 32'hC1, 32'hC2, 32'hC3), 8'b0000_1111);
    bus.memReq   = 1'b1;
    bus.memWrite = 1'b1;
    bus.memAddr  = 32'h300;
    step();
    chk("mid_ack", 32'(bus.memAck), 32'h1);
    bus.memReq    = 1'b0;
    bus.memWValid = 1'b1;
    bus.memWData  = 32'hD0;
    step();
    bus.memWData = 32'hD1;
    rst          = 1'b0;
    step();
    chk_idle_outputs("mid_reset");
    chk("mid_reset_rdata", bus.memRData, 32'h0);
    rst           = 1'b1;
    bus.memWValid = 1'b0;
    step();
    chk_idle_outputs("mid_release");
    do_read(32'h300, mk(32'hD0, 32'hC1, 32'hC2, 32'hC3));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
